// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode and phase definitions for the VeriRISC sequencer
package cpu_pkg;

    localparam int OPCODE_W = 3;

    localparam logic [OPCODE_W-1:0] HLT = 3'd0;
    localparam logic [OPCODE_W-1:0] SKZ = 3'd1;
    localparam logic [OPCODE_W-1:0] ADD = 3'd2;
    localparam logic [OPCODE_W-1:0] AND = 3'd3;
    localparam logic [OPCODE_W-1:0] XOR = 3'd4;
    localparam logic [OPCODE_W-1:0] LDA = 3'd5;
    localparam logic [OPCODE_W-1:0] STO = 3'd6;
    localparam logic [OPCODE_W-1:0] JMP = 3'd7;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    // Opcodes that read memory and write the result into the accumulator.
    function automatic logic is_alu_op(input logic [OPCODE_W-1:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/phase_counter.sv
// rtl/phase_counter.sv - 3-bit instruction phase counter with hold enable
module phase_counter
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   enable,
    output phase_t phase
);

    phase_t phase_next;

    // Phase register: reset forces the start of an instruction immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= INST_ADDR;
        end else begin
            phase <= phase_next;
        end
    end

    // Advance one phase per clock, wrapping STORE back to INST_ADDR; hold when disabled.
    always_comb begin
        phase_next = phase;
        if (enable) begin
            phase_next = phase_t'(phase + 3'd1);
        end
    end

endmodule

// File: rtl/controller.sv
// rtl/controller.sv - VeriRISC instruction sequencer and control strobe decode
module controller
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                halt,
    output logic                inc_pc,
    output logic                ld_ac,
    output logic                ld_pc,
    output logic                wr,
    output logic                data_e
);

    phase_t phase;
    logic   enable;
    logic   alu_op;

    assign alu_op = is_alu_op(opcode);

    // HLT freezes the sequencer in OP_ADDR; only reset leaves it.
    assign enable = !((phase == OP_ADDR) && (opcode == HLT));

    phase_counter u_phase_counter (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .phase  (phase)
    );

    // Strobe decode from the current phase, opcode and zero flag.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        halt   = 1'b0;
        inc_pc = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        unique case (phase)
            INST_ADDR: begin
                sel = 1'b1;
            end
            INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = (opcode == HLT);
            end
            OP_FETCH: begin
                rd = alu_op;
            end
            ALU_OP: begin
                rd     = alu_op;
                inc_pc = (opcode == SKZ) && zero;
                ld_pc  = (opcode == JMP);
                data_e = (opcode == STO);
            end
            STORE: begin
                rd     = alu_op;
                ld_ac  = alu_op;
                ld_pc  = (opcode == JMP);
                wr     = (opcode == STO);
                data_e = (opcode == STO);
            end
            default: begin
                sel = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/controller.md
# controller

Instruction sequencer for the VeriRISC CPU. Steps through an 8-phase fetch/execute cycle per instruction, decodes the 3-bit opcode from the instruction register, and drives the memory, program counter, instruction register, accumulator and ALU control strobes. Sits directly upstream of the ALU's accumulator path: it consumes the ALU's `a_is_zero` flag and produces the loads that capture `alu_out`.

## Interface
Parameters:
- `OPCODE_W`, default 3: opcode width; fixed at 3 for this ISA.

Ports:
- `clk`  input  1  system clock, rising-edge active
- `rst`  input  1  asynchronous, active-high reset
- `opcode`  input  OPCODE_W  current instruction opcode (from IR)
- `zero`  input  1  ALU `a_is_zero` flag (accumulator == 0)
- `sel`  output  1  memory address mux: 1 = PC, 0 = IR operand
- `rd`  output  1  memory read enable
- `ld_ir`  output  1  instruction register load
- `halt`  output  1  CPU halted
- `inc_pc`  output  1  program counter increment
- `ld_ac`  output  1  accumulator load (captures `alu_out`)
- `ld_pc`  output  1  program counter load (jump)
- `wr`  output  1  memory write enable
- `data_e`  output  1  accumulator-to-data-bus drive enable

## Operation
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = ADD|AND|XOR|LDA.
- 3-bit phase register, advances by 1 per clock, wraps 7 -> 0. One instruction = 8 clocks.
- Outputs are combinational decode of phase, `opcode`, `zero`; any output not listed is 0:
  - INST_ADDR (0): sel.
  - INST_FETCH (1): sel, rd.
  - INST_LOAD (2): sel, rd, ld_ir.
  - IDLE (3): sel, rd, ld_ir.
  - OP_ADDR (4): inc_pc; halt = (opcode==HLT).
  - OP_FETCH (5): rd = ALUOP.
  - ALU_OP (6): rd = ALUOP; inc_pc = (opcode==SKZ && zero); ld_pc = (opcode==JMP); data_e = (opcode==STO).
  - STORE (7): rd = ALUOP; ld_ac = ALUOP; ld_pc = (opcode==JMP); wr = (opcode==STO); data_e = (opcode==STO).
- Halt: in OP_ADDR with opcode==HLT, phase does not advance. Controller stays in OP_ADDR with `halt`=1 and `inc_pc`=1 asserted every cycle; PC/IR owners gate `inc_pc` with `halt`. Exit only via `rst`.
- SKZ with zero=0 and opcodes outside ALUOP/STO/JMP produce no strobes in phases 5-7.

## Timing
- Reset: phase = INST_ADDR immediately (async). While `rst`=1: `sel`=1, all other outputs 0. First advance on first rising edge after `rst` deasserts.
- Reset mid-instruction aborts it. A `wr` or `ld_ac` in progress is dropped at once.
- `opcode` is sampled combinationally. It is valid from phase 3 onward, once IR loaded at the phase 2->3 edge. The decode in phases 4-7 uses the current value.
- `zero` is sampled combinationally in phase 6 only.
- `ld_ac`, `ld_pc`, `wr` are pulse-style level strobes. The consuming register captures at the rising edge that ends the phase.
- No handshake; latency fixed at 8 cycles per instruction, except HLT, which never completes.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants HLT..JMP
  - phase encodings INST_ADDR..STORE
  - `OPCODE_W`
- Sub-module `phase_counter`: 3-bit counter with async active-high `rst` and an `enable` input. `enable` is driven low by the controller when halted.
- Controller top: one `phase_counter` instance plus the combinational output decode.

## Test plan
- Reset: assert `rst` mid-phase 5 with opcode=STO -> outputs immediately `sel`=1, all others 0. After release, 8 clocks cycle phases 0..7.
- ADD (opcode=2): phases 5-7 `rd`=1; `ld_ac`=1 only in phase 7; `wr`=`ld_pc`=0 throughout.
- STO (opcode=6): `data_e`=1 in phases 6-7; `wr`=1 only in phase 7; `rd`=0 in phases 5-7.
- SKZ (opcode=1): zero=1 -> `inc_pc`=1 in phases 4 and 6. zero=0 -> `inc_pc`=1 in phase 4 only.
- JMP (opcode=7): `ld_pc`=1 in phases 6 and 7; `ld_ac`=0.
- HLT (opcode=0): phase holds at 4 for 20+ clocks with `halt`=1. Then `rst` pulse -> phase 0, `halt`=0, normal sequencing resumes.
